alu_issue_seq: RTL
==================

Name: alu_issue_seq

Overview:
- Sequencer directly upstream and downstream of the 16-bit ALU (ALU control codes: 000 add, 001 sub, 010 and, 011 or, 100 slt).
- Accepts one register-format instruction at a time over a valid/ready handshake and reads its operands from an internal 8-entry register file.
- Drives the ALU operand and control inputs, waits out the ALU's registered latency, then writes the result back to the register file.
- Reports completion with status flags.

Parameters:
- WIDTH, 16: data width of registers and ALU operands.
- ALU_LATENCY, 1: number of clock edges from operands presented to ALU result valid; range 1-4.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- instr_valid  in  1  an instruction is offered on instr.
- instr  in  16  [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt, [3:0] ignored.
- instr_ready  out  1  block can accept an instruction this cycle.
- alu_a  out  WIDTH  operand A to the ALU (value of rs).
- alu_b  out  WIDTH  operand B to the ALU (value of rt).
- alu_control  out  3  ALU operation code.
- alu_result  in  WIDTH  registered ALU result.
- alu_overflow  in  1  registered ALU overflow.
- alu_slt  in  1  registered ALU less-than bit.
- done  out  1  one-cycle pulse when an instruction retires.
- done_rd  out  3  destination register of the retiring instruction.
- done_zero  out  1  value written is all zeros.
- done_ovf  out  1  arithmetic overflow on the retiring instruction.
- illegal  out  1  one-cycle pulse: op was 101-111; instruction dropped.
- dbg_addr  in  3  debug read address.
- dbg_data  out  WIDTH  combinational read of register dbg_addr.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - All registers r0-r7 cleared to 0; state returns to IDLE.
  - instr_ready=1; alu_a, alu_b, alu_control = 0.
  - done, done_rd, done_zero, done_ovf, illegal = 0.
  - Reset mid-instruction aborts it: no writeback, no done.
- Register file:
  - r0 always reads 0; writes to r0 are discarded, but done still pulses.
  - One write per retire; no other write path.
- FSM states: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready, latch instr.
  - If op > 100: pulse illegal next cycle and stay in IDLE.
  - Otherwise go to ISSUE.
- ISSUE:
  - Drive alu_a=R[rs], alu_b=R[rt], alu_control=op; instr_ready=0.
  - Operand outputs are registered and held stable until WB completes.
  - Load the wait counter with ALU_LATENCY-1, then go to WAIT (if ALU_LATENCY=1, go straight to WB).
- WAIT: decrement the counter; go to WB when it reaches 0.
- WB:
  - Write value V to R[rd]:
    - slt: V = {WIDTH-1 zeros, alu_slt}.
    - otherwise: V = alu_result.
  - done_zero = (V==0); the block computes this itself and does not use any ALU zero output.
  - done_ovf = alu_overflow for add/sub, 0 for and/or/slt.
  - done=1 for this one cycle; return to IDLE.
- Latency: accept edge to done pulse is ALU_LATENCY+2 cycles. Throughput is one instruction per ALU_LATENCY+2 cycles.
- Hazards: instructions execute strictly in order and never overlap, so a read-after-write on the next instruction sees the written value. No forwarding is needed.
- instr_valid while instr_ready=0 is ignored (the source must hold it).
- dbg_data reflects a write on the cycle after WB.

Optional Feature:
- Macro: ALU_ISSUE_OVF_TRAP_EN.
- Defined:
  - When done_ovf=1, the writeback to rd is suppressed and rd keeps its old value.
  - done still pulses with done_ovf=1.
  - done_zero reports the suppressed V.
- Undefined: overflowing results are written normally.

Test Plan:
- Reset, then read all r0-r7 via dbg_addr -> all 0, instr_ready=1, done=0.
- Preload r1=0x0005, r2=0x0003 via add from r0 (op 000 with an r1 operand chain built through ADD steps), then sub r3=r1-r2 -> done after 3 cycles (ALU_LATENCY=1), r3=0x0002, done_zero=0, done_ovf=0.
- r4=0x7FFF + r5=0x0001 add -> done_ovf=1; r6=0x8000 written, or left unchanged with ALU_ISSUE_OVF_TRAP_EN defined.
- slt r7,r2,r1 (3<5) -> r7=0x0001; slt r7,r1,r2 -> r7=0x0000 with done_zero=1.
- op=110 offered -> illegal pulse, no done, registers unchanged, instr_ready stays 1; write to rd=0 -> done pulses, r0 still 0.
- Assert reset_n=0 during WAIT with ALU_LATENCY=3 -> no done, rd unchanged (then all registers 0), back-to-back instructions afterward retire every 5 cycles.

Source files
------------

// File: rtl/alu_issue_seq.sv
// In-order issue/writeback sequencer wrapped around a registered 16-bit ALU, with an 8-entry register file.
// Optional build macro ALU_ISSUE_OVF_TRAP_EN: overflowing add/sub results are not written back.
module alu_issue_seq #(
  parameter int WIDTH       = 16,
  parameter int ALU_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             alu_slt,
  output logic             done,
  output logic [2:0]       done_rd,
  output logic             done_zero,
  output logic             done_ovf,
  output logic             illegal,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SLT = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] regs_r [8];
  logic [2:0]       op_r, rd_r, cnt_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic             ready_r, done_r, done_zero_r, done_ovf_r, illegal_r;
  logic [2:0]       done_rd_r;
  logic             accept_s, legal_s, ovf_s, wr_en_s;
  logic [WIDTH-1:0] wb_val_s;
  logic             unused_s;

  // slt retires the ALU's less-than bit, everything else retires the ALU result
  function automatic logic [WIDTH-1:0] wb_value(input logic [2:0] op,
                                                input logic [WIDTH-1:0] res,
                                                input logic slt);
    logic [WIDTH-1:0] v;
    if (op == OP_SLT) begin
      v = {{(WIDTH-1){1'b0}}, slt};
    end else begin
      v = res;
    end
    return v;
  endfunction

  assign unused_s = ^instr[3:0];

  // Next-state logic and instruction acceptance
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    legal_s  = (instr[15:13] <= OP_SLT);
    case (state_r)
      IDLE: begin
        if (instr_valid) begin
          accept_s = 1'b1;
          if (legal_s) begin
            state_s = ISSUE;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (ALU_LATENCY == 1) begin
          state_s = WB;
        end else begin
          state_s = WAIT;
        end
      end
      WAIT: begin
        if (cnt_r == 3'd1) begin
          state_s = WB;
        end else begin
          state_s = WAIT;
        end
      end
      WB:      state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Writeback value, overflow qualification and write enable
  always_comb begin
    wb_val_s = wb_value(op_r, alu_result, alu_slt);
    if (op_r == OP_ADD || op_r == OP_SUB) begin
      ovf_s = alu_overflow;
    end else begin
      ovf_s = 1'b0;
    end
`ifdef ALU_ISSUE_OVF_TRAP_EN
    wr_en_s = (state_r == WB) && (rd_r != 3'd0) && !ovf_s;
`else
    wr_en_s = (state_r == WB) && (rd_r != 3'd0);
`endif
  end

  // State, operand, status and register-file registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      op_r        <= 3'd0;
      rd_r        <= 3'd0;
      cnt_r       <= 3'd0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
      done_rd_r   <= 3'd0;
      done_zero_r <= 1'b0;
      done_ovf_r  <= 1'b0;
      illegal_r   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      state_r   <= state_s;
      ready_r   <= (state_s == IDLE);
      illegal_r <= accept_s && !legal_s;
      done_r    <= (state_r == WB);
      // operands are captured at acceptance so the ALU sees them throughout ISSUE
      if (accept_s && legal_s) begin
        op_r <= instr[15:13];
        rd_r <= instr[12:10];
        a_r  <= regs_r[instr[9:7]];
        b_r  <= regs_r[instr[6:4]];
      end
      if (state_r == ISSUE) begin
        cnt_r <= 3'(ALU_LATENCY - 1);
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r - 3'd1;
      end
      if (state_r == WB) begin
        done_rd_r   <= rd_r;
        done_zero_r <= (wb_val_s == {WIDTH{1'b0}});
        done_ovf_r  <= ovf_s;
      end
      if (wr_en_s) begin
        regs_r[rd_r] <= wb_val_s;
      end
    end
  end

  assign instr_ready = ready_r;
  assign alu_a       = a_r;
  assign alu_b       = b_r;
  assign alu_control = op_r;
  assign done        = done_r;
  assign done_rd     = done_rd_r;
  assign done_zero   = done_zero_r;
  assign done_ovf    = done_ovf_r;
  assign illegal     = illegal_r;
  assign dbg_data    = regs_r[dbg_addr];

endmodule
